// File: rtl/swim_pkg.sv
// Shared SWIM constants: FSM state encoding, bit-timing lengths in SWIM clocks,
// and the default pulse-width counter width.
package swim_pkg;

  localparam int unsigned CNT_W          = 12;

  // Low-phase and bit lengths in SWIM clock periods
  localparam int unsigned SWIM_LOW_SHORT = 2;
  localparam int unsigned SWIM_LOW_LONG  = 20;
  localparam int unsigned SWIM_BIT_LEN   = 22;
  localparam int unsigned SWIM_SYNC_LEN  = 128;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DATA   = 3'd1;
  localparam logic [2:0] ST_PARITY = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_ACK    = 3'd4;

endpackage

// File: rtl/swim_pulse_meas.sv
// SWIM line front end: 2-flop synchronizer, edge detect, saturating low-pulse
// width counter and line-high timeout counter.
module swim_pulse_meas #(
  parameter int unsigned CNT_W         = 12,
  parameter int unsigned FRAME_TIMEOUT = 400
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             swim_in,
  output logic             pulse_done,
  output logic [CNT_W-1:0] pulse_width,
  output logic             high_timeout
);

  logic             sync1;
  logic             sync2;
  logic             line_q;
  logic             fall;
  logic [CNT_W-1:0] width_cnt;
  logic [CNT_W-1:0] high_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      line_q <= 1'b1;
    end else begin
      sync1  <= swim_in;
      sync2  <= sync1;
      line_q <= sync2;
    end
  end

  assign fall        = line_q & ~sync2;
  assign pulse_done  = ~line_q & sync2;
  assign pulse_width = width_cnt;

  // The falling-edge cycle is itself the first low cycle, so restart at 1
  always_ff @(posedge clk) begin
    if (reset)
      width_cnt <= '0;
    else if (fall)
      width_cnt <= CNT_W'(1);
    else if (!sync2 && width_cnt != '1)
      width_cnt <= width_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset || !sync2)
      high_cnt <= '0;
    else if (!high_timeout)
      high_cnt <= high_cnt + CNT_W'(1);
  end

  assign high_timeout = (high_cnt >= CNT_W'(FRAME_TIMEOUT));

endmodule

// File: rtl/swim_rx.sv
// SWIM receiver: classifies low pulses into bits/sync and decodes start+8+parity
// frames onto a valid/ready byte stream. `define SWIM_RX_ACK_EN adds the ACK driver.
module swim_rx #(
  parameter int unsigned CLK_DIV       = 6,
  parameter int unsigned BIT_THRESH    = 66,
  parameter int unsigned SYNC_MIN      = 600,
  parameter int unsigned FRAME_TIMEOUT = 400,
  parameter int unsigned CNT_W         = swim_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             swim_in,
  input  logic             rx_en,
  output logic [7:0]       data_out,
  output logic             data_parity_err,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  output logic             sync_pulse,
  output logic [CNT_W-1:0] sync_width
`ifdef SWIM_RX_ACK_EN
  ,
  output logic             ack_drive_low
`endif
);

  import swim_pkg::*;

  if (SYNC_MIN <= BIT_THRESH || BIT_THRESH <= SWIM_LOW_SHORT * CLK_DIV) begin : g_bad_cfg
    $error("swim_rx: BIT_THRESH/SYNC_MIN inconsistent with CLK_DIV");
  end

  logic             pulse_done;
  logic             high_timeout;
  logic [CNT_W-1:0] pulse_width;
  logic [2:0]       state;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             frame_perr;
  logic             pulse_live;
  logic             is_sync;
  logic             bit_val;

  swim_pulse_meas #(
    .CNT_W        (CNT_W),
    .FRAME_TIMEOUT(FRAME_TIMEOUT)
  ) u_meas (
    .clk         (clk),
    .reset       (reset),
    .swim_in     (swim_in),
    .pulse_done  (pulse_done),
    .pulse_width (pulse_width),
    .high_timeout(high_timeout)
  );

  assign pulse_live = pulse_done && (state != ST_ACK);
  assign is_sync    = (pulse_width >= CNT_W'(SYNC_MIN));
  assign bit_val    = (pulse_width <  CNT_W'(BIT_THRESH));

`ifdef SWIM_RX_ACK_EN
  localparam int unsigned ACK_WAIT = SWIM_LOW_SHORT * CLK_DIV;
  localparam int unsigned ACK_LEN  = SWIM_LOW_SHORT * CLK_DIV;
  localparam int unsigned NACK_LEN = SWIM_LOW_LONG * CLK_DIV;

  logic [CNT_W-1:0] ack_cnt;
  logic [CNT_W-1:0] ack_release;

  assign ack_release = frame_perr ? CNT_W'(ACK_WAIT + NACK_LEN - 1)
                                  : CNT_W'(ACK_WAIT + ACK_LEN - 1);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      bit_cnt         <= '0;
      shreg           <= '0;
      frame_perr      <= 1'b0;
      data_out        <= '0;
      data_parity_err <= 1'b0;
      data_valid      <= 1'b0;
      overrun         <= 1'b0;
      sync_pulse      <= 1'b0;
      sync_width      <= '0;
`ifdef SWIM_RX_ACK_EN
      ack_cnt         <= '0;
      ack_drive_low   <= 1'b0;
`endif
    end else begin
      sync_pulse <= 1'b0;
      overrun    <= 1'b0;
      if (data_valid && data_ready)
        data_valid <= 1'b0;

      if (pulse_live && is_sync) begin
        sync_pulse <= 1'b1;
        sync_width <= pulse_width;
      end

      if (!rx_en || (pulse_live && is_sync)) begin
        state <= ST_IDLE;
`ifdef SWIM_RX_ACK_EN
        ack_drive_low <= 1'b0;
`endif
      end else begin
        case (state)
          ST_IDLE: begin
            if (pulse_live && bit_val) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            if (high_timeout)
              state <= ST_IDLE;
            else if (pulse_live) begin
              shreg   <= {shreg[6:0], bit_val};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7)
                state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            if (high_timeout)
              state <= ST_IDLE;
            else if (pulse_live) begin
              frame_perr <= bit_val ^ (^shreg);
              state      <= ST_DONE;
            end
          end
          ST_DONE: begin
            // A same-cycle transfer frees the slot, so the new byte still loads
            if (data_valid && !data_ready)
              overrun <= 1'b1;
            else begin
              data_out        <= shreg;
              data_parity_err <= frame_perr;
              data_valid      <= 1'b1;
            end
`ifdef SWIM_RX_ACK_EN
            ack_cnt <= '0;
            state   <= ST_ACK;
`else
            state   <= ST_IDLE;
`endif
          end
`ifdef SWIM_RX_ACK_EN
          ST_ACK: begin
            // Linger one SWIM clock after release so our own rising edge is ignored
            ack_cnt <= ack_cnt + CNT_W'(1);
            if (ack_cnt == CNT_W'(ACK_WAIT - 1))
              ack_drive_low <= 1'b1;
            if (ack_cnt == ack_release)
              ack_drive_low <= 1'b0;
            if (ack_cnt == ack_release + CNT_W'(CLK_DIV))
              state <= ST_IDLE;
          end
`endif
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_swim_rx.sv
// Self-checking bench for swim_rx: scoreboard of expected bytes checked on each
// valid/ready transfer, plus per-scenario checks of sync, latency, backpressure, timeout, reset.
module tb_swim_rx;

  import swim_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        swim_in = 1'b1;
  logic        rx_en = 1'b1;
  logic        data_ready = 1'b1;
  logic [7:0]  data_out;
  logic        data_parity_err;
  logic        data_valid;
  logic        overrun;
  logic        sync_pulse;
  logic [11:0] sync_width;
`ifdef SWIM_RX_ACK_EN
  logic        ack_drive_low;
  int          ack_low_cycles = 0;
`endif

  int passed = 0;
  int total = 0;
  int valid_cycles = 0;
  int overrun_cnt = 0;
  logic [8:0] exp_q[$];
  logic [8:0] exp_item;

  always #5 clk = ~clk;

  swim_rx #(
    .CLK_DIV      (6),
    .BIT_THRESH   (66),
    .SYNC_MIN     (600),
    .FRAME_TIMEOUT(400),
    .CNT_W        (12)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .swim_in        (swim_in),
    .rx_en          (rx_en),
    .data_out       (data_out),
    .data_parity_err(data_parity_err),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .overrun        (overrun),
    .sync_pulse     (sync_pulse),
    .sync_width     (sync_width)
`ifdef SWIM_RX_ACK_EN
    ,
    .ack_drive_low  (ack_drive_low)
`endif
  );

  // Scoreboard: every transfer must match the oldest expected byte
  always @(negedge clk) begin
    if (!reset) begin
      if (data_valid) valid_cycles++;
      if (overrun) overrun_cnt++;
`ifdef SWIM_RX_ACK_EN
      if (ack_drive_low) ack_low_cycles++;
`endif
      if (data_valid && data_ready) begin
        total++;
        if (exp_q.size() == 0)
          $display("FAIL sb_unexpected: got data_out=%h perr=%b, required no transfer", data_out, data_parity_err);
        else begin
          exp_item = exp_q.pop_front();
          if ({data_parity_err, data_out} !== exp_item)
            $display("FAIL sb_byte: got perr=%b data=%h, required perr=%b data=%h",
                     data_parity_err, data_out, exp_item[8], exp_item[7:0]);
          else
            passed++;
        end
      end
    end
  end

  task automatic hold(input logic v, input int n);
    swim_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    if (b) begin
      hold(1'b0, 12);
      hold(1'b1, 120);
    end else begin
      hold(1'b0, 120);
      hold(1'b1, 12);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) send_bit(b[i]);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic par);
    hold(1'b1, 150);
    send_bit(1'b1);
    send_bits(b, 8);
    send_bit(par);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({data_out, data_parity_err, data_valid, overrun, sync_pulse, sync_width} !== 24'h0)
      $display("FAIL reset_outputs: got %h, required 0",
               {data_out, data_parity_err, data_valid, overrun, sync_pulse, sync_width});
    else passed++;
    total++;
    if (dut.state !== ST_IDLE) $display("FAIL reset_state: got %0d, required %0d", dut.state, ST_IDLE);
    else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    hold(1'b1, 10);
  endtask

  task automatic test_sync;
    int found;
    found = 0;
    hold(1'b0, 768);
    swim_in = 1'b1;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (sync_pulse) found = 1;
    end
    total++;
    if (found != 1) $display("FAIL sync_seen: got sync_pulse=0 within 20 cycles, required 1");
    else passed++;
    total++;
    if (sync_width < 12'd766 || sync_width > 12'd770)
      $display("FAIL sync_width: got %0d, required 768+-2", sync_width);
    else passed++;
    @(negedge clk);
    total++;
    if (sync_pulse !== 1'b0) $display("FAIL sync_one_cycle: got %b, required 0", sync_pulse);
    else passed++;
    total++;
    if ({dut.state, data_valid} !== {ST_IDLE, 1'b0})
      $display("FAIL sync_idle: got state=%0d valid=%b, required state=%0d valid=0", dut.state, data_valid, ST_IDLE);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_byte_a5;
    int v0, lat;
    data_ready = 1'b1;
    v0 = valid_cycles;
    lat = 0;
    exp_q.push_back({1'b0, 8'hA5});
    hold(1'b1, 150);
    send_bit(1'b1);
    send_bits(8'hA5, 8);
    hold(1'b0, 120);
    swim_in = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (data_valid && lat == 0) lat = i;
    end
    total++;
    if (lat != 5) $display("FAIL a5_latency: got valid at negedge %0d, required 5", lat);
    else passed++;
    @(posedge clk); #1;
    hold(1'b1, 30);
    total++;
    if (valid_cycles - v0 != 1) $display("FAIL a5_valid_width: got %0d cycles, required 1", valid_cycles - v0);
    else passed++;
    total++;
    if (exp_q.size() != 0) $display("FAIL a5_delivered: got %0d pending, required 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_parity_err;
`ifdef SWIM_RX_ACK_EN
    int a0;
    a0 = ack_low_cycles;
`endif
    exp_q.push_back({1'b1, 8'h3C});
    send_byte(8'h3C, 1'b1);
    hold(1'b1, 150);
    total++;
    if (exp_q.size() != 0) $display("FAIL perr_delivered: got %0d pending, required 0", exp_q.size());
    else passed++;
`ifdef SWIM_RX_ACK_EN
    total++;
    if (ack_low_cycles - a0 != 120) $display("FAIL nack_width: got %0d, required 120", ack_low_cycles - a0);
    else passed++;
`endif
  endtask

  task automatic test_backpressure;
    int o0;
    data_ready = 1'b0;
    o0 = overrun_cnt;
    exp_q.push_back({1'b0, 8'h11});
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    hold(1'b1, 20);
    @(negedge clk);
    total++;
    if (data_out !== 8'h11) $display("FAIL bp_hold_data: got %h, required 11", data_out);
    else passed++;
    total++;
    if (data_valid !== 1'b1) $display("FAIL bp_hold_valid: got %b, required 1", data_valid);
    else passed++;
    total++;
    if (overrun_cnt - o0 != 1) $display("FAIL bp_overrun: got %0d pulses, required 1", overrun_cnt - o0);
    else passed++;
    @(posedge clk); #1;
    data_ready = 1'b1;
    hold(1'b1, 3);
    @(negedge clk);
    total++;
    if (data_valid !== 1'b0) $display("FAIL bp_valid_fall: got %b, required 0", data_valid);
    else passed++;
    total++;
    if (exp_q.size() != 0) $display("FAIL bp_delivered: got %0d pending, required 0", exp_q.size());
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout;
    int v0;
    v0 = valid_cycles;
    exp_q.push_back({1'b0, 8'h5A});
    hold(1'b1, 150);
    send_bit(1'b1);
    send_bits(8'hA0, 3);
    hold(1'b1, 400);
    send_byte(8'h5A, 1'b0);
    hold(1'b1, 30);
    total++;
    if (valid_cycles - v0 != 1) $display("FAIL to_single_byte: got %0d valid cycles, required 1", valid_cycles - v0);
    else passed++;
    total++;
    if (exp_q.size() != 0) $display("FAIL to_delivered: got %0d pending, required 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_reset_midframe;
    // Leave one byte pending so reset visibly clears it
    data_ready = 1'b0;
    send_byte(8'h77, 1'b1);
    hold(1'b1, 150);
    send_bit(1'b1);
    send_bits(8'h81, 4);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({data_out, data_parity_err, data_valid, overrun, sync_pulse, sync_width} !== 24'h0)
      $display("FAIL rst_mid_outputs: got %h, required 0",
               {data_out, data_parity_err, data_valid, overrun, sync_pulse, sync_width});
    else passed++;
    total++;
    if (dut.state !== ST_IDLE) $display("FAIL rst_mid_state: got %0d, required %0d", dut.state, ST_IDLE);
    else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    data_ready = 1'b1;
    exp_q.push_back({1'b0, 8'h81});
    send_byte(8'h81, 1'b0);
    hold(1'b1, 30);
    total++;
    if (exp_q.size() != 0) $display("FAIL rst_mid_delivered: got %0d pending, required 0", exp_q.size());
    else passed++;
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset;
    test_sync;
    test_byte_a5;
    test_parity_err;
    test_backpressure;
    test_timeout;
    test_reset_midframe;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
